// File: rtl/wbu_commit.sv
// wbu_commit: in-order writeback result buffer that commits one instruction per cycle and halts on ebreak.
// Optional macro WBU_PERF_COUNTER_EN adds a 64-bit retired-instruction counter (retired_cnt_o).
//
// state | meaning
// RUN   | accepting results and committing the head entry
// HALT  | ebreak committed; buffer frozen until reset
module wbu_commit #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        wbu_valid_pre_i,
    output logic        wbu_ready_pre_o,
    input  logic        wena_i,
    input  logic [4:0]  waddr_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] pc_i,
    input  logic [31:0] inst_i,
    input  logic        commit_hold_i,
    output logic        commit_valid_o,
    output logic        commit_wena_o,
    output logic [4:0]  commit_waddr_o,
    output logic [31:0] commit_wdata_o,
    output logic [31:0] commit_pc_o,
    output logic [31:0] commit_inst_o,
    output logic        halt_o
`ifdef WBU_PERF_COUNTER_EN
    ,
    output logic [63:0] retired_cnt_o
`endif
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [31:0] EBREAK = 32'h0010_0073;
    localparam logic [0:0] RUN  = 1'b0;
    localparam logic [0:0] HALT = 1'b1;

    typedef struct packed {
        logic        wena;
        logic [4:0]  waddr;
        logic [31:0] wdata;
        logic [31:0] pc;
        logic [31:0] inst;
    } entry_t;

    entry_t        mem [DEPTH];
    entry_t        head;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   cnt;
    logic [0:0]    state;
    logic          empty;
    logic          push;
    logic          pop;

    assign empty = (cnt == '0);
    assign head  = mem[rd_ptr];

    assign wbu_ready_pre_o = (cnt < (AW+1)'(DEPTH)) && (state == RUN);
    assign commit_valid_o  = !empty && !commit_hold_i && (state == RUN);
    assign halt_o          = (state == HALT);

    assign push = wbu_valid_pre_i && wbu_ready_pre_o;
    assign pop  = commit_valid_o;

    // Storage is never reset, so every head field is masked while empty.
    assign commit_wena_o  = empty ? 1'b0  : head.wena;
    assign commit_waddr_o = empty ? 5'd0  : head.waddr;
    assign commit_wdata_o = empty ? 32'd0 : head.wdata;
    assign commit_pc_o    = empty ? 32'd0 : head.pc;
    assign commit_inst_o  = empty ? 32'd0 : head.inst;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= '{wena: wena_i, waddr: waddr_i, wdata: wdata_i,
                             pc: pc_i, inst: inst_i};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (push && !pop) begin
                cnt <= cnt + (AW+1)'(1);
            end else if (pop && !push) begin
                cnt <= cnt - (AW+1)'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= RUN;
        end else if (state == RUN && pop && head.inst == EBREAK) begin
            state <= HALT;
        end
    end

`ifdef WBU_PERF_COUNTER_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            retired_cnt_o <= 64'd0;
        end else if (pop) begin
            retired_cnt_o <= retired_cnt_o + 64'd1;
        end
    end
`endif

endmodule

// File: tb/tb_wbu_commit.sv
// Bench for wbu_commit: queue-based reference model checked every cycle, directed scenarios, then random traffic.
// Build with WBU_PERF_COUNTER_EN defined to also check retired_cnt_o.
module tb_wbu_commit;

    localparam int DEPTH = 4;
    localparam logic [31:0] EBREAK = 32'h0010_0073;

    typedef struct {
        logic        wena;
        logic [4:0]  waddr;
        logic [31:0] wdata;
        logic [31:0] pc;
        logic [31:0] inst;
    } ent_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        wbu_valid_pre_i = 1'b0;
    logic        wbu_ready_pre_o;
    logic        wena_i = 1'b0;
    logic [4:0]  waddr_i = '0;
    logic [31:0] wdata_i = '0;
    logic [31:0] pc_i = '0;
    logic [31:0] inst_i = '0;
    logic        commit_hold_i = 1'b0;
    logic        commit_valid_o;
    logic        commit_wena_o;
    logic [4:0]  commit_waddr_o;
    logic [31:0] commit_wdata_o;
    logic [31:0] commit_pc_o;
    logic [31:0] commit_inst_o;
    logic        halt_o;
`ifdef WBU_PERF_COUNTER_EN
    logic [63:0] retired_cnt_o;
`endif

    wbu_commit #(.DEPTH(DEPTH)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .wbu_valid_pre_i(wbu_valid_pre_i),
        .wbu_ready_pre_o(wbu_ready_pre_o),
        .wena_i         (wena_i),
        .waddr_i        (waddr_i),
        .wdata_i        (wdata_i),
        .pc_i           (pc_i),
        .inst_i         (inst_i),
        .commit_hold_i  (commit_hold_i),
        .commit_valid_o (commit_valid_o),
        .commit_wena_o  (commit_wena_o),
        .commit_waddr_o (commit_waddr_o),
        .commit_wdata_o (commit_wdata_o),
        .commit_pc_o    (commit_pc_o),
        .commit_inst_o  (commit_inst_o),
        .halt_o         (halt_o)
`ifdef WBU_PERF_COUNTER_EN
        ,
        .retired_cnt_o  (retired_cnt_o)
`endif
    );

    always #5 clk = ~clk;

    int    n_total = 0;
    int    n_pass  = 0;
    bit    cmp_en  = 1'b1;

    ent_t        q[$];
    bit          halted = 1'b0;
    logic [63:0] retired = 64'd0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    endtask

    // Reference model: a plain queue of accepted results plus a halted flag.
    always @(negedge rst_n) begin
        q.delete();
        halted  = 1'b0;
        retired = 64'd0;
    end

    always @(posedge clk) begin
        if (rst_n) begin
            bit   acc;
            bit   pop;
            ent_t e;
            acc = wbu_valid_pre_i && !halted && (q.size() < DEPTH);
            pop = !halted && (q.size() > 0) && !commit_hold_i;
            if (pop) begin
                e = q.pop_front();
                retired++;
                if (e.inst == EBREAK) halted = 1'b1;
            end
            if (acc) q.push_back('{wena_i, waddr_i, wdata_i, pc_i, inst_i});
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            ent_t h;
            h = (q.size() > 0) ? q[0] : '{1'b0, 5'd0, 32'd0, 32'd0, 32'd0};
            chk("ready", wbu_ready_pre_o, !halted && q.size() < DEPTH);
            chk("commit_valid", commit_valid_o, !halted && q.size() > 0 && !commit_hold_i);
            chk("halt", halt_o, halted);
            chk("wena", commit_wena_o, h.wena);
            chk("waddr", commit_waddr_o, h.waddr);
            chk("wdata", commit_wdata_o, h.wdata);
            chk("pc", commit_pc_o, h.pc);
            chk("inst", commit_inst_o, h.inst);
`ifdef WBU_PERF_COUNTER_EN
            chk("retired", retired_cnt_o, retired);
`endif
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic drive(input bit v, input logic [31:0] d, input logic [31:0] ins);
        wbu_valid_pre_i = v;
        wena_i  = 1'b1;
        waddr_i = d[4:0];
        wdata_i = d;
        pc_i    = 32'h8000_0000 + (d << 2);
        inst_i  = ins;
    endtask

    task automatic do_reset();
        wbu_valid_pre_i = 1'b0;
        commit_hold_i   = 1'b0;
        @(posedge clk);
        #3 rst_n = 1'b0;
        @(posedge clk);
        #3 rst_n = 1'b1;
        tick();
    endtask

    initial begin
        do_reset();
        chk("rst_ready", wbu_ready_pre_o, 1'b1);
        chk("rst_valid", commit_valid_o, 1'b0);
        chk("rst_halt", halt_o, 1'b0);

        // Single result: visible for exactly one cycle.
        drive(1'b1, 32'hDEAD_BEEF, 32'h0000_0013);
        waddr_i = 5'd5;
        tick();
        wbu_valid_pre_i = 1'b0;
        #1;
        chk("single_valid", commit_valid_o, 1'b1);
        chk("single_waddr", commit_waddr_o, 5'd5);
        chk("single_wdata", commit_wdata_o, 32'hDEAD_BEEF);
        chk("single_wena", commit_wena_o, 1'b1);
        tick();
        chk("single_gone", commit_valid_o, 1'b0);

        // Hold high, five attempts: four fit, then ready drops.
        commit_hold_i = 1'b1;
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 32'(i + 1), 32'h0000_0013);
            #1;
            chk("fill_ready", wbu_ready_pre_o, (i < 4) ? 1'b1 : 1'b0);
            tick();
        end
        chk("fill_occ_model", q.size(), 4);
        wbu_valid_pre_i = 1'b0;
        commit_hold_i   = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("drain_valid", commit_valid_o, 1'b1);
            chk("drain_wdata", commit_wdata_o, 32'(i + 1));
            tick();
        end
        chk("drain_ready", wbu_ready_pre_o, 1'b1);
        chk("drain_empty", commit_valid_o, 1'b0);

        // Streaming: one in, one out per cycle, pointers wrap.
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, 32'(100 + i), 32'h0000_0013);
            tick();
            chk("stream_valid", commit_valid_o, 1'b1);
            chk("stream_wdata", commit_wdata_o, 32'(100 + i));
            chk("stream_occ_model", q.size(), 1);
        end
        wbu_valid_pre_i = 1'b0;
        tick();
        chk("stream_done", commit_valid_o, 1'b0);

        // ebreak with two entries behind it.
        commit_hold_i = 1'b1;
        drive(1'b1, 32'h11, EBREAK);
        tick();
        drive(1'b1, 32'h12, 32'h0000_0013);
        tick();
        drive(1'b1, 32'h13, 32'h0000_0013);
        tick();
        wbu_valid_pre_i = 1'b0;
        commit_hold_i   = 1'b0;
        #1;
        chk("ebreak_valid", commit_valid_o, 1'b1);
        chk("ebreak_inst", commit_inst_o, EBREAK);
        tick();
        for (int i = 0; i < 3; i++) begin
            chk("halt_set", halt_o, 1'b1);
            chk("halt_valid", commit_valid_o, 1'b0);
            chk("halt_ready", wbu_ready_pre_o, 1'b0);
            tick();
        end

        // Asynchronous reset with three entries buffered.
        do_reset();
        commit_hold_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 32'(7 + i), 32'h0000_0013);
            tick();
        end
        wbu_valid_pre_i = 1'b0;
        #1;
        chk("pre_rst_wdata", commit_wdata_o, 32'd7);
        rst_n = 1'b0;
        #1;
        chk("async_wdata", commit_wdata_o, 32'd0);
        chk("async_wena", commit_wena_o, 1'b0);
        chk("async_valid", commit_valid_o, 1'b0);
        chk("async_model_occ", q.size(), 0);
        commit_hold_i = 1'b0;
        #3 rst_n = 1'b1;
        tick();
        chk("post_rst_valid", commit_valid_o, 1'b0);
        chk("post_rst_ready", wbu_ready_pre_o, 1'b1);

`ifdef WBU_PERF_COUNTER_EN
        do_reset();
        for (int i = 0; i < 7; i++) begin
            drive(1'b1, 32'(i), 32'h0000_0013);
            tick();
        end
        wbu_valid_pre_i = 1'b0;
        commit_hold_i   = 1'b1;
        tick();
        tick();
        commit_hold_i = 1'b0;
        tick();
        chk("perf_7", retired_cnt_o, 64'd7);
`endif

        // Random traffic with occasional ebreak; reset whenever the model has halted for a while.
        do_reset();
        begin
            int halt_cycles = 0;
            for (int c = 0; c < 3000; c++) begin
                drive($urandom_range(0, 9) < 7, $urandom,
                      ($urandom_range(0, 59) == 0) ? EBREAK : $urandom);
                wena_i        = $urandom_range(0, 1) == 1;
                commit_hold_i = $urandom_range(0, 9) < 3;
                if (halted) halt_cycles++;
                if (halt_cycles > 6) begin
                    halt_cycles = 0;
                    do_reset();
                end else begin
                    tick();
                end
            end
        end

        wbu_valid_pre_i = 1'b0;
        tick();
        cmp_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
